regfile_wb_scheduler: RTL

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

---
 rtl/regfile_wb_scheduler.sv | 115 +++++++++++
 1 files changed

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for a 32-entry register file.
// Arbitrates two writeback requesters (ALU, load unit) onto one registered
// write port and tracks registers reserved by decode for hazard queries.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   req0_valid/addr/data, req0_ready   requester 0 (ALU) valid/ready channel
//   req1_valid/addr/data, req1_ready   requester 1 (load unit) valid/ready channel
//   wen, a3, wd                        registered register-file write port
//   issue_valid, issue_rd              decode reservation of a destination register
//   q1, q2, q1_pending, q2_pending     source-register hazard queries
//   idle                               nothing pending and no write in flight
module regfile_wb_scheduler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        wen,
    output logic [4:0]  a3,
    output logic [31:0] wd,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  q1,
    input  logic [4:0]  q2,
    output logic        q1_pending,
    output logic        q2_pending,
    output logic        idle
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;

    logic          last_grant_q, last_grant_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] a3_q, a3_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [NR-1:0] pending_q, pending_d;

    logic          grant0, grant1, xfer;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic [NR-1:0] set_vec, clr_vec;

    // Round-robin grant; last_grant_q=1 means requester 1 won last, so 0 has priority.
    always_comb begin
        grant0 = reset_n && req0_valid && (!req1_valid || last_grant_q);
        grant1 = reset_n && req1_valid && (!req0_valid || !last_grant_q);
        xfer   = grant0 || grant1;
        sel_addr = grant1 ? req1_addr : req0_addr;
        sel_data = grant1 ? req1_data : req0_data;
    end

    // Next-state for arbitration history and the write port.
    always_comb begin
        last_grant_d = last_grant_q;
        wen_d        = 1'b0;
        a3_d         = a3_q;
        wd_d         = wd_q;
        if (xfer) begin
            last_grant_d = grant1;
            wen_d        = (sel_addr != AW'(0));
            a3_d         = sel_addr;
            wd_d         = sel_data;
        end
    end

    // Pending scoreboard: clear on the edge the register file writes, set wins over clear.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && (issue_rd != AW'(0))) begin
            set_vec = NR'(1) << issue_rd;
        end
        if (wen_q) begin
            clr_vec = NR'(1) << a3_q;
        end
        pending_d    = (pending_q & ~clr_vec) | set_vec;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            wen_q        <= 1'b0;
            a3_q         <= '0;
            wd_q         <= '0;
            pending_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            a3_q         <= a3_d;
            wd_q         <= wd_d;
            pending_q    <= pending_d;
        end
    end

    // Combinational handshake and query outputs; bit 0 of pending is never set.
    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        wen        = wen_q;
        a3         = a3_q;
        wd         = wd_q;
        q1_pending = pending_q[q1];
        q2_pending = pending_q[q2];
        idle       = (pending_q == '0) && !wen_q;
    end

endmodule
